// File: rtl/notch_pkg.sv
// Shared constants, state encoding and reset defaults for the notch coefficient loader.
package notch_pkg;
    localparam int COEFF_W   = 16;
    localparam int NUM_COEFF = 5;
    localparam int ADDR_W    = 3;

    localparam int ADDR_A1 = 0;
    localparam int ADDR_A2 = 1;
    localparam int ADDR_B0 = 2;
    localparam int ADDR_B1 = 3;
    localparam int ADDR_B2 = 4;

    localparam logic [COEFF_W-1:0] B0_RESET    = 16'h4000;
    localparam logic [COEFF_W-1:0] OTHER_RESET = 16'h0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIRTY   = 2'd1,
        PENDING = 2'd2
    } state_t;

    typedef logic [NUM_COEFF-1:0][COEFF_W-1:0] coeff_set_t;

    // Pass-through filter: B0 = 1.0 in Q2.14, every other tap zero.
    function automatic logic [COEFF_W-1:0] coeff_reset(input int idx);
        return (idx == ADDR_B0) ? B0_RESET : OTHER_RESET;
    endfunction
endpackage

// File: rtl/coeff_bank.sv
// Coefficient register array with per-entry write and a single-edge bulk load.
module coeff_bank
    import notch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_COEFF-1:0] i_we,
    input  logic [COEFF_W-1:0]   i_wdata,
    input  logic                 i_load,
    input  coeff_set_t           i_load_data,
    output coeff_set_t           o_q
);
    coeff_set_t r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_COEFF; i++) r_q[i] <= coeff_reset(i);
        end else if (i_load) begin
            r_q <= i_load_data;
        end else begin
            for (int i = 0; i < NUM_COEFF; i++)
                if (i_we[i]) r_q[i] <= i_wdata;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/notch_coeff_loader.sv
// Shadow/active coefficient banks; a commit is applied atomically on the next sample tick.
module notch_coeff_loader
    import notch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [COEFF_W-1:0] wr_data,
    input  logic               commit,
    input  logic               sample_tick,
    output logic [COEFF_W-1:0] A1,
    output logic [COEFF_W-1:0] A2,
    output logic [COEFF_W-1:0] B0,
    output logic [COEFF_W-1:0] B1,
    output logic [COEFF_W-1:0] B2,
    output logic               pending,
    output logic               coeff_applied,
    output logic               addr_err
);
    state_t               r_state;
    state_t               w_next_state;
    logic                 w_wr_ready;
    logic                 w_pending;
    logic                 w_apply;
    logic                 w_wr_fire;
    logic                 w_bad_addr;
    logic [NUM_COEFF-1:0] w_we;
    logic                 r_applied;
    logic                 r_addr_err;
    coeff_set_t           w_shadow;
    coeff_set_t           w_active;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (commit)         w_next_state = PENDING;
                else if (w_wr_fire) w_next_state = DIRTY;
            end
            DIRTY:   if (commit)      w_next_state = PENDING;
            PENDING: if (sample_tick) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // A tick in the commit cycle sees IDLE/DIRTY, so only later ticks apply.
    always_comb begin
        w_wr_ready = (r_state != PENDING);
        w_pending  = (r_state == PENDING);
        w_apply    = (r_state == PENDING) && sample_tick;
    end

    assign w_wr_fire  = wr_valid && w_wr_ready;
    assign w_bad_addr = (wr_addr >= ADDR_W'(NUM_COEFF));

    always_comb begin
        w_we = '0;
        for (int i = 0; i < NUM_COEFF; i++)
            if (w_wr_fire && (wr_addr == ADDR_W'(i))) w_we[i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_applied  <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_applied <= w_apply;
            if (w_apply)                      r_addr_err <= 1'b0;
            else if (w_wr_fire && w_bad_addr) r_addr_err <= 1'b1;
        end
    end

    coeff_bank u_shadow (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_we        (w_we),
        .i_wdata     (wr_data),
        .i_load      (1'b0),
        .i_load_data ('0),
        .o_q         (w_shadow)
    );

    coeff_bank u_active (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_we        ('0),
        .i_wdata     ('0),
        .i_load      (w_apply),
        .i_load_data (w_shadow),
        .o_q         (w_active)
    );

    assign wr_ready      = w_wr_ready;
    assign pending       = w_pending;
    assign coeff_applied = r_applied;
    assign addr_err      = r_addr_err;
    assign A1            = w_active[ADDR_A1];
    assign A2            = w_active[ADDR_A2];
    assign B0            = w_active[ADDR_B0];
    assign B1            = w_active[ADDR_B1];
    assign B2            = w_active[ADDR_B2];
endmodule

// File: tb/tb_notch_coeff_loader.sv
// Scoreboard bench: stimulus queues expected coefficient sets, a monitor checks each apply pulse.
module tb_notch_coeff_loader;
    import notch_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               wr_valid;
    logic               wr_ready;
    logic [ADDR_W-1:0]  wr_addr;
    logic [COEFF_W-1:0] wr_data;
    logic               commit;
    logic               sample_tick;
    logic [COEFF_W-1:0] A1, A2, B0, B1, B2;
    logic               pending;
    logic               coeff_applied;
    logic               addr_err;

    typedef struct packed {
        logic [15:0] a1, a2, b0, b1, b2;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    notch_coeff_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .commit        (commit),
        .sample_tick   (sample_tick),
        .A1            (A1),
        .A2            (A2),
        .B0            (B0),
        .B1            (B1),
        .B2            (B2),
        .pending       (pending),
        .coeff_applied (coeff_applied),
        .addr_err      (addr_err)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
    endtask

    // Monitor: every apply pulse must match the oldest queued set.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && coeff_applied === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL apply_unexpected: got coeff_applied=1 expected no apply");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("apply_A1", A1, e.a1);
                chk("apply_A2", A2, e.a2);
                chk("apply_B0", B0, e.b0);
                chk("apply_B1", B1, e.b1);
                chk("apply_B2", B2, e.b2);
            end
        end
    end

    initial begin
        exp_t s1, s2, s3;
        s1 = '{a1:16'hC4B2, a2:16'h3A00, b0:16'h3F00, b1:16'hC200, b2:16'h3F00};
        s2 = s1; s2.b0 = 16'h1234;
        s3 = s2; s3.b1 = 16'h0123;

        rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        commit = 1'b0; sample_tick = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        chk("rst_A1", A1, 16'h0000);
        chk("rst_A2", A2, 16'h0000);
        chk("rst_B0", B0, 16'h4000);
        chk("rst_B1", B1, 16'h0000);
        chk("rst_B2", B2, 16'h0000);
        chk("rst_wr_ready", 16'(wr_ready), 16'd1);
        chk("rst_pending", 16'(pending), 16'd0);
        chk("rst_addr_err", 16'(addr_err), 16'd0);

        // Basic load, commit, delayed tick
        wr(3'd0, 16'hC4B2);
        wr(3'd1, 16'h3A00);
        wr(3'd2, 16'h3F00);
        wr(3'd3, 16'hC200);
        wr(3'd4, 16'h3F00);
        chk("dirty_B0_hold", B0, 16'h4000);
        commit = 1'b1;
        exp_q.push_back(s1);
        cyc();
        commit = 1'b0;
        chk("commit_pending", 16'(pending), 16'd1);
        chk("commit_B0_hold", B0, 16'h4000);
        chk("commit_A1_hold", A1, 16'h0000);
        // Backpressured write held across the apply
        wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 16'h1234;
        cyc();
        chk("bp_wr_ready", 16'(wr_ready), 16'd0);
        cyc();
        chk("bp_B0_hold", B0, 16'h4000);
        tick();
        chk("apply_pending_clr", 16'(pending), 16'd0);
        chk("apply_pulse", 16'(coeff_applied), 16'd1);
        chk("apply_wr_ready", 16'(wr_ready), 16'd1);
        cyc();
        wr_valid = 1'b0;
        chk("pulse_single", 16'(coeff_applied), 16'd0);
        chk("bp_active_B0", B0, 16'h3F00);

        // Commit together with tick: tick ignored
        commit = 1'b1; sample_tick = 1'b1;
        exp_q.push_back(s2);
        cyc();
        commit = 1'b0; sample_tick = 1'b0;
        chk("same_pending", 16'(pending), 16'd1);
        chk("same_no_pulse", 16'(coeff_applied), 16'd0);
        chk("same_B0_hold", B0, 16'h3F00);
        cyc();
        tick();
        chk("same_B0_apply", B0, 16'h1234);

        // Write plus commit in one cycle; second commit while pending ignored
        wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 16'h0123; commit = 1'b1;
        exp_q.push_back(s3);
        cyc();
        wr_valid = 1'b0;
        cyc();
        commit = 1'b0;
        chk("recommit_pending", 16'(pending), 16'd1);
        chk("recommit_B1_hold", B1, 16'hC200);
        tick();
        chk("wc_B1_apply", B1, 16'h0123);
        cyc();

        // Bad address
        wr(3'd5, 16'h7FFF);
        chk("bad_addr_err", 16'(addr_err), 16'd1);
        chk("bad_A1_hold", A1, 16'hC4B2);
        tick();
        chk("idle_tick_no_pulse", 16'(coeff_applied), 16'd0);
        chk("idle_tick_err_hold", 16'(addr_err), 16'd1);
        wr(3'd7, 16'h5555);
        commit = 1'b1;
        exp_q.push_back(s3);
        cyc();
        commit = 1'b0;
        chk("bad_err_pending", 16'(addr_err), 16'd1);
        tick();
        chk("bad_err_clr", 16'(addr_err), 16'd0);
        cyc();

        // Reset while pending drops the commit
        wr(3'd3, 16'h2000);
        commit = 1'b1;
        cyc();
        commit = 1'b0;
        chk("mid_pending", 16'(pending), 16'd1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("mid_B1", B1, 16'h0000);
        chk("mid_B0", B0, 16'h4000);
        chk("mid_pending_clr", 16'(pending), 16'd0);
        chk("mid_no_pulse", 16'(coeff_applied), 16'd0);
        tick(); cyc(); tick(); cyc();
        chk("mid_tick_B1", B1, 16'h0000);
        chk("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish by 100000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/notch_coeff_loader.md
Name: notch_coeff_loader

Overview:
- Write side of the IIR notch filter's coefficient interface. Accepts coefficient writes over a valid/ready handshake into a shadow bank.
- On a commit request it transfers all five coefficients (A1, A2, B0, B1, B2) to an active bank atomically, on a sample boundary.
- The filter never sees a mixed old/new coefficient set. The active bank drives the filter's A1/A2/B0/B1/B2 inputs directly.

Parameters:
- COEFF_W, 16, coefficient width (signed, Q2.14).
- NUM_COEFF, 5, number of coefficients in the bank.
- ADDR_W, 3, coefficient address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  loader can accept a write.
- wr_addr  in  ADDR_W  coefficient index: 0=A1, 1=A2, 2=B0, 3=B1, 4=B2.
- wr_data  in  COEFF_W  signed coefficient value.
- commit  in  1  single-cycle request to apply the shadow bank.
- sample_tick  in  1  sample-boundary strobe, one cycle per filter input sample.
- A1, A2, B0, B1, B2  out  COEFF_W each  active coefficients, signed, registered.
- pending  out  1  commit accepted, waiting for sample_tick.
- coeff_applied  out  1  one-cycle pulse in the first cycle new coefficients are visible.
- addr_err  out  1  sticky flag: a write to an address >= NUM_COEFF was accepted.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low on rst_n, sampled only at the rising edge of clk.
- Reset values:
  - Active and shadow banks reset to pass-through: B0=16'h4000 (1.0); A1, A2, B1, B2 = 0.
  - pending=0, coeff_applied=0, addr_err=0, wr_ready=1, FSM=IDLE.
- FSM states: IDLE (shadow equals active), DIRTY (shadow modified since last apply), PENDING (commit accepted).
  - IDLE -> DIRTY on an accepted write.
  - IDLE or DIRTY -> PENDING on commit.
  - PENDING -> IDLE on sample_tick.
- Write handshake:
  - wr_ready = (state != PENDING).
  - A write occurs when wr_valid && wr_ready at the clock edge. shadow[wr_addr] <= wr_data.
  - The active bank is unaffected by writes.
- Bad address: wr_addr >= NUM_COEFF is still accepted (handshake completes). Data is discarded and addr_err is set. addr_err clears only on apply or reset.
- Commit:
  - commit in IDLE or DIRTY moves to PENDING next cycle; pending=1.
  - A write and commit in the same cycle: the write lands in shadow and is included in the commit.
  - commit while in PENDING is ignored; no error is raised.
- Apply:
  - In PENDING, the first sample_tick strictly after the commit cycle copies all five shadow entries to the active bank in one edge.
  - A sample_tick in the same cycle as commit does not count.
  - Latency: commit at cycle t, first qualifying tick at cycle t' > t. Outputs change and coeff_applied=1 at t'+1. pending=0 at t'+1.
- Outputs A1..B2 are registered. They change only on an apply edge or on reset, so they stay glitch-free between samples.
- sample_tick outside PENDING has no effect.
- Reset mid-operation (including while PENDING): both banks return to pass-through defaults, and the pending commit is dropped. No coeff_applied pulse is generated by reset.
- Width rules: coefficients are passed bit-exact, with no saturation or scaling. wr_addr uses the full ADDR_W bits for the range check.

Decomposition:
- Shared package (notch_pkg):
  - COEFF_W, NUM_COEFF, ADDR_W.
  - Address constants ADDR_A1..ADDR_B2.
  - Reset defaults (B0_RESET=16'h4000, others 0).
  - FSM state encoding (IDLE=2'd0, DIRTY=2'd1, PENDING=2'd2).
- Sub-module: coeff_bank. A NUM_COEFF x COEFF_W register array with synchronous active-low reset to package defaults, per-entry write enable, and a bulk-load port. It is instantiated twice: once as the shadow bank and once as the active bank.

Test Plan:
- Reset check: hold rst_n=0 for 2 cycles, release -> B0=0x4000; A1=A2=B1=B2=0; wr_ready=1; pending=0; addr_err=0.
- Basic load and apply:
  - Write A1=0xC4B2, A2=0x3A00, B0=0x3F00, B1=0xC200, B2=0x3F00, then commit -> outputs stay at defaults while pending=1.
  - Raise sample_tick 3 cycles later -> next cycle all five outputs equal the written values, with a single-cycle coeff_applied pulse.
- Backpressure:
  - While PENDING, drive wr_valid with B0=0x1234 -> wr_ready=0 and shadow is unchanged.
  - After apply, the held write is accepted -> shadow B0=0x1234; active B0 unchanged until the next commit and tick.
- Same-cycle events:
  - commit together with sample_tick -> no apply that cycle.
  - Next sample_tick -> apply.
  - Write plus commit in the same cycle -> the written value appears in the applied set.
- Bad address: write addr=5, data=0x7FFF -> handshake completes, addr_err=1, no coefficient changes. commit plus tick -> addr_err=0.
- Reset mid-operation: load B1=0x2000, commit, assert rst_n=0 before any tick -> B1=0, pending=0, and no coeff_applied pulse on the following ticks.
